// File: rtl/seq_pattern_detector_if.sv
// Signal bundle for the serial pattern detector: sample/config inputs plus
// match and status outputs. The master side drives the stream, the slave
// side is the detector itself.
interface seq_pattern_detector_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic             x;
   logic             cfg_we;
   logic [PAT_W-1:0] pat_in;
   logic             cnt_clr;
   logic             y;
   logic             y_q;
   logic [CNT_W-1:0] match_cnt;
   logic [4:0]       fill;

   modport master (
      output en, x, cfg_we, pat_in, cnt_clr,
      input  y, y_q, match_cnt, fill
   );

   modport slave (
      input  en, x, cfg_we, pat_in, cnt_clr,
      output y, y_q, match_cnt, fill
   );
endinterface

// File: rtl/seq_pattern_detector.sv
// Parametrised serial Mealy pattern detector. Keeps the last PAT_W-1 accepted
// bits and compares them, together with the bit arriving this cycle, against
// a programmable pattern. y is combinational (same cycle as the final bit),
// y_q is its registered copy, and match_cnt counts matches with saturation.
module seq_pattern_detector #(
   parameter int               PAT_W   = 4,
   parameter logic [PAT_W-1:0] PATTERN = 4'b1101,
   parameter bit               OVERLAP = 1'b1,
   parameter int               CNT_W   = 8
) (
   input logic                 clk,
   input logic                 rst,
   seq_pattern_detector_if.slave bus
);

   // History is full once it holds PAT_W-1 bits; the incoming bit completes the window.
   localparam logic [4:0]       FULL    = 5'(PAT_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [PAT_W-2:0] hist;
   logic [PAT_W-1:0] pat_q;
   logic [4:0]       depth;
   logic [PAT_W-1:0] window;
   logic             hit;
   logic             y_reg;
   logic [CNT_W-1:0] cnt;

   // The candidate window is the stored history followed by the live bit;
   // dropping its MSB also gives the next history, which works for PAT_W=2 too.
   assign window = {hist, bus.x};

   // A config write steals the cycle, so no match can be reported alongside it.
   assign hit = bus.en & ~bus.cfg_we & (depth == FULL) & (window == pat_q);

   assign bus.y         = hit & ~rst;
   assign bus.y_q       = y_reg;
   assign bus.match_cnt = cnt;
   assign bus.fill      = depth;

   // History, valid depth and pattern register; config write wins over a sample.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist  <= '0;
         depth <= '0;
         pat_q <= PATTERN;
      end else if (bus.cfg_we) begin
         pat_q <= bus.pat_in;
         hist  <= '0;
         depth <= '0;
      end else if (bus.en) begin
         if (!OVERLAP && hit) begin
            hist  <= '0;
            depth <= '0;
         end else begin
            hist  <= window[PAT_W-2:0];
            depth <= (depth == FULL) ? FULL : depth + 5'd1;
         end
      end
   end

   // One-cycle delayed copy of the Mealy output for consumers that want a clean flop.
   always_ff @(posedge clk) begin
      if (rst) begin
         y_reg <= 1'b0;
      end else begin
         y_reg <= bus.y;
      end
   end

   // Saturating match counter; a clear coinciding with a hit keeps that hit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (bus.cnt_clr) begin
         cnt <= hit ? CNT_ONE : '0;
      end else if (hit && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end
   end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Self-checking bench for seq_pattern_detector. Two detectors (overlapping and
// non-overlapping) see the same stream; a stream-history model checks every
// cycle and directed literal checks pin the model.
module tb_seq_pattern_detector;

   localparam int         PAT_W   = 4;
   localparam int         CNT_W   = 8;
   localparam logic [3:0] PATTERN = 4'b1101;

   logic       clk;
   logic       rst;
   logic       en;
   logic       x;
   logic       cfg_we;
   logic [3:0] pat_in;
   logic       cnt_clr;

   int checks;
   int errors;
   bit model_ok;

   seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_ov ();
   seq_pattern_detector_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) bus_no ();

   assign bus_ov.en      = en;
   assign bus_ov.x       = x;
   assign bus_ov.cfg_we  = cfg_we;
   assign bus_ov.pat_in  = pat_in;
   assign bus_ov.cnt_clr = cnt_clr;
   assign bus_no.en      = en;
   assign bus_no.x       = x;
   assign bus_no.cfg_we  = cfg_we;
   assign bus_no.pat_in  = pat_in;
   assign bus_no.cnt_clr = cnt_clr;

   seq_pattern_detector #(.PAT_W(PAT_W), .PATTERN(PATTERN), .OVERLAP(1'b1), .CNT_W(CNT_W)) dut_ov (
      .clk (clk),
      .rst (rst),
      .bus (bus_ov)
   );

   seq_pattern_detector #(.PAT_W(PAT_W), .PATTERN(PATTERN), .OVERLAP(1'b0), .CNT_W(CNT_W)) dut_no (
      .clk (clk),
      .rst (rst),
      .bus (bus_no)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Index 0 = overlapping detector, index 1 = non-overlapping detector.
   logic       dut_y    [2];
   logic       dut_yq   [2];
   logic [7:0] dut_cnt  [2];
   logic [4:0] dut_fill [2];

   assign dut_y[0]    = bus_ov.y;
   assign dut_y[1]    = bus_no.y;
   assign dut_yq[0]   = bus_ov.y_q;
   assign dut_yq[1]   = bus_no.y_q;
   assign dut_cnt[0]  = bus_ov.match_cnt;
   assign dut_cnt[1]  = bus_no.match_cnt;
   assign dut_fill[0] = bus_no.fill == bus_no.fill ? bus_ov.fill : bus_ov.fill;
   assign dut_fill[1] = bus_no.fill;

   // Model: every accepted bit is appended to a stream; the valid history is
   // the part of the stream after the last clear point.
   bit         stream [2][0:2047];
   int         m_total [2];
   int         m_start [2];
   int         m_cnt   [2];
   logic [3:0] m_pat   [2];
   bit         m_prev_y[2];

   function automatic bit model_hit(int d);
      int base;
      if (!en || cfg_we) return 1'b0;
      if (m_total[d] - m_start[d] < PAT_W - 1) return 1'b0;
      base = m_total[d] - (PAT_W - 1);
      for (int k = 0; k < PAT_W - 1; k++) begin
         if (stream[d][base + k] != m_pat[d][PAT_W - 1 - k]) return 1'b0;
      end
      return x == m_pat[d][0];
   endfunction

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Compare every cycle, then advance the model with this cycle's inputs.
   always @(negedge clk) begin
      bit h;
      int exp_fill;
      for (int d = 0; d < 2; d++) begin
         h = model_hit(d) && !rst;
         if (model_ok) begin
            exp_fill = m_total[d] - m_start[d];
            if (exp_fill > PAT_W - 1) exp_fill = PAT_W - 1;
            checkOutput($sformatf("model y[%0d]", d), int'(dut_y[d]), int'(h));
            checkOutput($sformatf("model y_q[%0d]", d), int'(dut_yq[d]), int'(m_prev_y[d]));
            checkOutput($sformatf("model cnt[%0d]", d), int'(dut_cnt[d]), m_cnt[d]);
            checkOutput($sformatf("model fill[%0d]", d), int'(dut_fill[d]), exp_fill);
         end
         if (rst) begin
            m_total[d]  = 0;
            m_start[d]  = 0;
            m_cnt[d]    = 0;
            m_pat[d]    = PATTERN;
            m_prev_y[d] = 1'b0;
         end else begin
            m_prev_y[d] = h;
            if (cnt_clr) m_cnt[d] = h ? 1 : 0;
            else if (h && m_cnt[d] < 255) m_cnt[d] = m_cnt[d] + 1;
            if (cfg_we) begin
               m_pat[d]   = pat_in;
               m_start[d] = m_total[d];
            end else if (en) begin
               stream[d][m_total[d]] = x;
               m_total[d] = m_total[d] + 1;
               if (d == 1 && h) m_start[d] = m_total[d];
            end
         end
      end
      if (rst) model_ok = 1'b1;
   end

   task automatic applyStimulus(input bit r, input bit e, input bit b, input bit we,
                                input logic [3:0] p, input bit clr);
      @(posedge clk);
      #1;
      rst     = r;
      en      = e;
      x       = b;
      cfg_we  = we;
      pat_in  = p;
      cnt_clr = clr;
      #2;
   endtask

   logic [6:0] t1_bits;
   logic [3:0] t6_bits;

   initial begin
      checks   = 0;
      errors   = 0;
      model_ok = 1'b0;
      rst      = 1'b1;
      en       = 1'b0;
      x        = 1'b0;
      cfg_we   = 1'b0;
      pat_in   = 4'b0000;
      cnt_clr  = 1'b0;
      t1_bits  = 7'b1101101;
      t6_bits  = 4'b1101;

      $display("[TB] reset");
      applyStimulus(1, 0, 0, 0, 4'b0000, 0);
      applyStimulus(1, 0, 0, 0, 4'b0000, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);
      checkOutput("reset cnt", int'(bus_ov.match_cnt), 0);
      checkOutput("reset fill", int'(bus_ov.fill), 0);
      checkOutput("reset y_q", int'(bus_ov.y_q), 0);

      $display("[TB] stream 1101101, overlap and non-overlap");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(0, 1, t1_bits[6 - i], 0, 4'b0000, 0);
         checkOutput($sformatf("t1 y_ov bit%0d", i + 1), int'(bus_ov.y), (i == 3 || i == 6) ? 1 : 0);
         checkOutput($sformatf("t1 y_no bit%0d", i + 1), int'(bus_no.y), (i == 3) ? 1 : 0);
         if (i == 4) checkOutput("t1 y_q after bit4", int'(bus_ov.y_q), 1);
      end
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);
      checkOutput("t1 y_q after bit7", int'(bus_ov.y_q), 1);
      checkOutput("t1 cnt_ov", int'(bus_ov.match_cnt), 2);
      checkOutput("t1 cnt_no", int'(bus_no.match_cnt), 1);
      checkOutput("t1 fill_no", int'(bus_no.fill), 3);

      $display("[TB] gaps in enable");
      applyStimulus(1, 0, 0, 0, 4'b0000, 0);
      applyStimulus(0, 1, 1, 0, 4'b0000, 0);
      applyStimulus(0, 1, 1, 0, 4'b0000, 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 0, 1, 0, 4'b0000, 0);
         checkOutput("t3 fill held", int'(bus_ov.fill), 2);
         checkOutput("t3 y gap", int'(bus_ov.y), 0);
      end
      applyStimulus(0, 1, 0, 0, 4'b0000, 0);
      checkOutput("t3 y bit3", int'(bus_ov.y), 0);
      applyStimulus(0, 1, 1, 0, 4'b0000, 0);
      checkOutput("t3 y_ov final", int'(bus_ov.y), 1);
      checkOutput("t3 y_no final", int'(bus_no.y), 1);

      $display("[TB] pattern reload to 0000");
      applyStimulus(1, 0, 0, 0, 4'b0000, 0);
      applyStimulus(0, 1, 1, 1, 4'b0000, 0);
      checkOutput("t4 y on cfg", int'(bus_ov.y), 0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(0, 1, 0, 0, 4'b0000, 0);
         if (i == 0) checkOutput("t4 fill after cfg", int'(bus_ov.fill), 0);
         checkOutput($sformatf("t4 y_ov zero%0d", i + 1), int'(bus_ov.y), (i >= 3) ? 1 : 0);
      end
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);
      checkOutput("t4 cnt_ov", int'(bus_ov.match_cnt), 3);
      checkOutput("t4 cnt_no", int'(bus_no.match_cnt), 1);

      $display("[TB] counter saturation");
      for (int i = 0; i < 253; i++) applyStimulus(0, 1, 0, 0, 4'b0000, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);
      checkOutput("t5 cnt saturated", int'(bus_ov.match_cnt), 255);
      applyStimulus(0, 1, 0, 0, 4'b0000, 1);
      checkOutput("t5 y with clr", int'(bus_ov.y), 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);
      checkOutput("t5 clr with hit", int'(bus_ov.match_cnt), 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 1);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);
      checkOutput("t5 clr alone", int'(bus_ov.match_cnt), 0);

      $display("[TB] reset mid-pattern");
      applyStimulus(1, 0, 0, 0, 4'b0000, 0);
      applyStimulus(0, 1, 1, 0, 4'b0000, 0);
      applyStimulus(0, 1, 1, 0, 4'b0000, 0);
      applyStimulus(0, 1, 0, 0, 4'b0000, 0);
      applyStimulus(1, 1, 1, 0, 4'b0000, 0);
      checkOutput("t6 y during rst", int'(bus_ov.y), 0);
      applyStimulus(0, 1, 1, 0, 4'b0000, 0);
      checkOutput("t6 fill after rst", int'(bus_ov.fill), 0);
      checkOutput("t6 lone bit y", int'(bus_ov.y), 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, t6_bits[3 - i], 0, 4'b0000, 0);
         checkOutput($sformatf("t6 y_ov bit%0d", i + 1), int'(bus_ov.y), (i == 3) ? 1 : 0);
         if (i == 3) checkOutput("t6 y_no final", int'(bus_no.y), 1);
      end
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);
      applyStimulus(0, 0, 0, 0, 4'b0000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
